// File: rtl/fetch_buffer_pkg.sv
// rtl/fetch_buffer_pkg.sv - shared widths and queue entry layout for the fetch buffer
package fetch_buffer_pkg;

  localparam int ADDR_WIDTH  = 32;
  localparam int INSTR_WIDTH = 32;

  typedef struct packed {
    logic [1:0][ADDR_WIDTH-1:0]  pc;
    logic                        slot1_ok;
    logic [1:0]                  pred;
    logic [1:0][INSTR_WIDTH-1:0] instr;
    logic                        filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// rtl/fetch_buffer_if.sv - predictor, instruction-memory and decode signals of the fetch buffer
interface fetch_buffer_if;
  import fetch_buffer_pkg::*;

  logic [1:0][ADDR_WIDTH-1:0]  pc_in;
  logic [1:0]                  pc_valid_in;
  logic [1:0]                  pred_branch_in;
  logic                        stall_out;
  logic                        imem_req_valid;
  logic [ADDR_WIDTH-1:0]       imem_req_addr;
  logic                        imem_req_ready;
  logic                        imem_resp_valid;
  logic [63:0]                 imem_resp_data;
  logic [1:0]                  dec_valid;
  logic [1:0][INSTR_WIDTH-1:0] dec_instr;
  logic [1:0][ADDR_WIDTH-1:0]  dec_pc;
  logic [1:0]                  dec_pred_branch;
  logic                        dec_ready;

  modport slave (
    input  pc_in, pc_valid_in, pred_branch_in, imem_req_ready, imem_resp_valid,
    input  imem_resp_data, dec_ready,
    output stall_out, imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
    output dec_pred_branch
  );

  modport master (
    output pc_in, pc_valid_in, pred_branch_in, imem_req_ready, imem_resp_valid,
    output imem_resp_data, dec_ready,
    input  stall_out, imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
    input  dec_pred_branch
  );

endinterface

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - two-wide fetch stage with an in-order queue of in-flight instruction pairs
// A redirect empties the queue and turns outstanding requests into responses to drop.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ext_flush,
  fetch_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t r_q [DEPTH];
  logic [PW-1:0] r_alloc_ptr;
  logic [PW-1:0] r_fill_ptr;
  logic [PW-1:0] r_head_ptr;
  logic [CW-1:0] r_occ;
  logic [CW-1:0] r_drop_cnt;

  logic [CW-1:0] w_unfilled;
  logic [CW:0]   w_credit_used;
  logic          w_req_valid;
  logic          w_accept;
  logic          w_dec_valid0;
  logic          w_pop;
  logic          w_slot1_ok;
  fetch_entry_t  w_head;

  // Allocated entries still waiting for their memory response.
  always_comb begin
    w_unfilled = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < r_occ) && !r_q[r_head_ptr + PW'(i)].filled) begin
        w_unfilled = w_unfilled + CW'(1);
      end
    end
  end

  assign w_credit_used = {1'b0, r_occ} + {1'b0, r_drop_cnt};
  assign w_req_valid   = bus.pc_valid_in[0] & ~ext_flush & ~reset &
                         (w_credit_used < (CW+1)'(DEPTH));
  assign w_accept      = w_req_valid & bus.imem_req_ready;
  assign w_head        = r_q[r_head_ptr];
  assign w_dec_valid0  = (r_occ != '0) & w_head.filled;
  assign w_pop         = w_dec_valid0 & bus.dec_ready;
  assign w_slot1_ok    = bus.pc_valid_in[1] & ~bus.pred_branch_in[0] &
                         (bus.pc_in[1] == bus.pc_in[0] + ADDR_WIDTH'(4));

  assign bus.imem_req_valid  = w_req_valid;
  assign bus.imem_req_addr   = bus.pc_in[0];
  assign bus.stall_out       = ~w_accept;
  assign bus.dec_valid       = {w_dec_valid0 & w_head.slot1_ok, w_dec_valid0};
  assign bus.dec_instr       = w_head.instr;
  assign bus.dec_pc          = w_head.pc;
  assign bus.dec_pred_branch = w_head.pred;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_head_ptr  <= '0;
      r_occ       <= '0;
      r_drop_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= '0;
      end
    end else if (ext_flush) begin
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_head_ptr  <= '0;
      r_occ       <= '0;
      r_drop_cnt  <= r_drop_cnt + w_unfilled - CW'(bus.imem_resp_valid);
    end else begin
      if (bus.imem_resp_valid) begin
        if (r_drop_cnt != '0) begin
          r_drop_cnt <= r_drop_cnt - CW'(1);
        end else begin
          r_q[r_fill_ptr].instr  <= bus.imem_resp_data;
          r_q[r_fill_ptr].filled <= 1'b1;
          r_fill_ptr             <= r_fill_ptr + PW'(1);
        end
      end
      if (w_accept) begin
        r_q[r_alloc_ptr].pc       <= bus.pc_in;
        r_q[r_alloc_ptr].slot1_ok <= w_slot1_ok;
        r_q[r_alloc_ptr].pred     <= bus.pred_branch_in;
        r_q[r_alloc_ptr].filled   <= 1'b0;
        r_alloc_ptr               <= r_alloc_ptr + PW'(1);
      end
      if (w_pop) begin
        r_head_ptr <= r_head_ptr + PW'(1);
      end
      r_occ <= r_occ + CW'(w_accept) - CW'(w_pop);
    end
  end

  a_drop_bound: assert property (@(posedge clk) disable iff (reset)
    ({1'b0, r_drop_cnt} + {1'b0, w_unfilled}) <= (CW+1)'(DEPTH));

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - directed scoreboard bench for fetch_buffer with an in-order memory model
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic ext_flush;

  fetch_buffer_if bus ();

  fetch_buffer #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .ext_flush (ext_flush),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t        memq [$];
  logic [159:0] sb   [$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lat     = 1;
  int n_acc;
  logic [31:0] next_pc;

  logic [31:0] d_pc0, d_pc1;
  logic d_v0, d_v1, d_p0, d_p1, d_flush, d_ready, d_dec_ready;
  logic s_accept, s_stall, s_req_valid, s_pop;
  logic [31:0] s_addr;
  logic [1:0] s_dec_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00000013;
    if (a == 32'h4) return 32'h00100093;
    return 32'hC0DE0000 | (a & 32'h0000FFFF);
  endfunction

  function automatic logic [159:0] exp_rec(input logic [31:0] pc0, input logic [31:0] pc1,
                                           input logic v1, input logic p0, input logic p1);
    logic ok;
    ok = v1 & ~p0 & (pc1 == pc0 + 32'd4);
    return {29'b0, pc0, pc1, ok, p1, p0, mem_word(pc0), mem_word(pc0 + 32'd4)};
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic [159:0] obs;
    logic [159:0] exp;
    mreq_t m;
    @(negedge clk);
    bus.pc_in[0]       = d_pc0;
    bus.pc_in[1]       = d_pc1;
    bus.pc_valid_in    = {d_v1, d_v0};
    bus.pred_branch_in = {d_p1, d_p0};
    ext_flush          = d_flush;
    bus.imem_req_ready = d_ready;
    bus.dec_ready      = d_dec_ready;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = {mem_word(memq[0].addr + 32'd4), mem_word(memq[0].addr)};
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
    end
    #1;
    s_req_valid = bus.imem_req_valid;
    s_accept    = bus.imem_req_valid & bus.imem_req_ready;
    s_stall     = bus.stall_out;
    s_addr      = bus.imem_req_addr;
    s_dec_valid = bus.dec_valid;
    s_pop       = bus.dec_valid[0] & bus.dec_ready;
    if (s_pop) begin
      obs = {29'b0, bus.dec_pc[0], bus.dec_pc[1], bus.dec_valid[1], bus.dec_pred_branch[1],
             bus.dec_pred_branch[0], bus.dec_instr[0], bus.dec_instr[1]};
      exp = (sb.size() > 0) ? sb.pop_front() : {160{1'b1}};
      chk("dec_pair", obs, exp);
    end
    if (s_accept) begin
      chk("req_addr", 160'(s_addr), 160'(d_pc0));
      m.addr = d_pc0;
      m.due  = cyc + lat;
      memq.push_back(m);
      sb.push_back(exp_rec(d_pc0, d_pc1, d_v1, d_p0, d_p1));
    end
    if (bus.imem_resp_valid) void'(memq.pop_front());
    if (d_flush) sb.delete();
    cyc++;
  endtask

  task automatic pair(input logic [31:0] pc);
    d_pc0 = pc;
    d_pc1 = pc + 32'd4;
    d_v0  = 1'b1;
    d_v1  = 1'b1;
    d_p0  = 1'b0;
    d_p1  = 1'b0;
  endtask

  task automatic drain();
    d_v0 = 1'b0;
    d_v1 = 1'b0;
    d_flush = 1'b0;
    d_dec_ready = 1'b1;
    for (int i = 0; i < 100 && (sb.size() > 0 || memq.size() > 0); i++) cycle();
    chk("drain_sb_empty", 160'(sb.size()), 160'(0));
    chk("drain_mem_empty", 160'(memq.size()), 160'(0));
    cycle();
    chk("drain_idle", 160'(s_dec_valid), 160'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ext_flush = 1'b0;
    bus.pc_in = '0;
    bus.pc_valid_in = '0;
    bus.pred_branch_in = '0;
    bus.imem_req_ready = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data = '0;
    bus.dec_ready = 1'b1;
    d_flush = 1'b0;
    d_ready = 1'b1;
    d_dec_ready = 1'b1;
    pair(32'h0);

    cycle();
    cycle();
    chk("reset_req_valid", 160'(s_req_valid), 160'(0));
    chk("reset_stall", 160'(s_stall), 160'(1));
    chk("reset_dec_valid", 160'(s_dec_valid), 160'(0));
    d_v0 = 1'b0;
    d_v1 = 1'b0;
    bus.pc_valid_in = '0;
    reset = 1'b0;

    // Basic fetch with 1-cycle memory
    lat = 1;
    pair(32'h0);
    cycle();
    chk("basic_accept", 160'(s_accept), 160'(1));
    chk("basic_stall", 160'(s_stall), 160'(0));
    d_v0 = 1'b0;
    d_v1 = 1'b0;
    cycle();
    chk("basic_dec_n1", 160'(s_dec_valid), 160'(0));
    cycle();
    chk("basic_dec_n2", 160'(s_dec_valid), 160'(2'b11));
    drain();

    // Back-pressure: decode stalled, memory always ready
    d_dec_ready = 1'b0;
    next_pc = 32'h1000;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      pair(next_pc);
      cycle();
      if (s_accept) begin
        n_acc++;
        next_pc = next_pc + 32'd8;
      end
    end
    chk("bp_accepts", 160'(n_acc), 160'(4));
    chk("bp_full_stall", 160'(s_stall), 160'(1));
    d_dec_ready = 1'b1;
    pair(next_pc);
    cycle();
    chk("bp_pop", 160'(s_pop), 160'(1));
    chk("bp_no_same_cycle_credit", 160'(s_accept), 160'(0));
    d_dec_ready = 1'b0;
    cycle();
    chk("bp_accept_after_pop", 160'(s_accept), 160'(1));
    next_pc = next_pc + 32'd8;
    pair(next_pc);
    cycle();
    chk("bp_full_again", 160'(s_stall), 160'(1));
    drain();

    // Slot-1 kill: predicted-taken slot 0, non-sequential pc1, invalid slot 1
    d_pc0 = 32'h40; d_pc1 = 32'h44; d_v0 = 1'b1; d_v1 = 1'b1; d_p0 = 1'b1; d_p1 = 1'b0;
    cycle();
    chk("kill_taken_accept", 160'(s_accept), 160'(1));
    d_pc0 = 32'h80; d_pc1 = 32'h88; d_p0 = 1'b0; d_p1 = 1'b1;
    cycle();
    chk("kill_gap_accept", 160'(s_accept), 160'(1));
    d_pc0 = 32'hC0; d_pc1 = 32'hC4; d_v1 = 1'b0; d_p1 = 1'b0;
    cycle();
    chk("kill_taken_dec", 160'(s_dec_valid), 160'(2'b01));
    d_v0 = 1'b0;
    cycle();
    chk("kill_gap_dec", 160'(s_dec_valid), 160'(2'b01));
    drain();

    // Flush with three requests in flight, 5-cycle memory
    lat = 5;
    n_acc = 0;
    for (int i = 0; i < 3; i++) begin
      pair(32'h200 + 32'(i * 8));
      cycle();
      if (s_accept) n_acc++;
    end
    chk("fl_inflight", 160'(n_acc), 160'(3));
    pair(32'h218);
    d_flush = 1'b1;
    cycle();
    chk("fl_no_req", 160'(s_req_valid), 160'(0));
    chk("fl_stall", 160'(s_stall), 160'(1));
    d_flush = 1'b0;
    pair(32'h100);
    cycle();
    chk("fl_redirect_accept", 160'(s_accept), 160'(1));
    pair(32'h108);
    cycle();
    chk("fl_drop_credit", 160'(s_stall), 160'(1));
    drain();

    // Second flush while still dropping
    lat = 6;
    pair(32'h300);
    cycle();
    pair(32'h308);
    cycle();
    pair(32'h310);
    d_flush = 1'b1;
    cycle();
    d_flush = 1'b0;
    pair(32'h400);
    cycle();
    chk("fd_accept_d", 160'(s_accept), 160'(1));
    pair(32'h408);
    d_flush = 1'b1;
    cycle();
    d_flush = 1'b0;
    pair(32'h500);
    cycle();
    chk("fd_accept_e", 160'(s_accept), 160'(1));
    pair(32'h508);
    cycle();
    chk("fd_drop3_stall", 160'(s_stall), 160'(1));
    drain();

    // Asynchronous reset in the middle of a burst
    lat = 3;
    d_dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pair(32'h600 + 32'(i * 8));
      cycle();
    end
    d_v0 = 1'b0;
    d_v1 = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    chk("ar_before", 160'(s_dec_valid), 160'(2'b11));
    @(negedge clk);
    bus.pc_valid_in = 2'b01;
    #2;
    reset = 1'b1;
    #1;
    chk("ar_dec_valid", 160'(bus.dec_valid), 160'(0));
    chk("ar_req_valid", 160'(bus.imem_req_valid), 160'(0));
    chk("ar_stall", 160'(bus.stall_out), 160'(1));
    sb.delete();
    memq.delete();
    bus.pc_valid_in = '0;
    @(negedge clk);
    #1;
    reset = 1'b0;
    next_pc = 32'h700;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      pair(next_pc);
      cycle();
      if (s_accept) begin
        n_acc++;
        next_pc = next_pc + 32'd8;
      end
    end
    chk("ar_credits", 160'(n_acc), 160'(4));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Two-wide instruction fetch stage directly downstream of the next-PC predictor. Each cycle it turns the predictor's PC pair into one 64-bit instruction-memory request, tracks in-flight requests in an in-order queue, and presents fetched instruction pairs with their PCs and prediction bits to decode. It back-pressures the predictor through `stall_out`, and on a redirect it discards all buffered and in-flight fetches.

## Interface
- `DEPTH`, 4: pair entries in the queue; power of two, ≥2.
- `INSTR_WIDTH`, 32: instruction width.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ext_flush`  in  1  redirect; drop everything buffered and in flight.
- `pc_in[2]`  in  `ADDR_WIDTH`  PC pair from the predictor (`guess`).
- `pc_valid_in[2]`  in  1  slot valid (`guess_valid`).
- `pred_branch_in[2]`  in  1  slot predicted taken (`guesses_branch`).
- `stall_out`  out  1  pair not accepted this cycle; drives the predictor's `ext_stall`.
- `imem_req_valid`  out  1  fetch request.
- `imem_req_addr`  out  `ADDR_WIDTH`  request address, equal to `pc_in[0]`.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_resp_valid`  in  1  response; responses arrive in order, one per accepted request, latency ≥1.
- `imem_resp_data`  in  64  [31:0] is the word at addr; [63:32] is the word at addr+4.
- `dec_valid[2]`  out  1  slot valid to decode.
- `dec_instr[2]`  out  `INSTR_WIDTH`  instruction.
- `dec_pc[2]`  out  `ADDR_WIDTH`  PC.
- `dec_pred_branch[2]`  out  1  prediction bit.
- `dec_ready`  in  1  decode consumes the head pair.

## Operation
- **Queue.** Circular queue of `DEPTH` entries. Each entry holds `pc[2]`, `slot1_ok`, `pred[2]`, `instr[2]` and `filled`.
- **Pointers.** `alloc_ptr` (tail), `fill_ptr` and `head_ptr`, plus an occupancy count `occ` and a drop counter `drop_cnt` of width clog2(DEPTH+1).
- **Request.** `imem_req_valid = pc_valid_in[0] & ~ext_flush & ~reset & (occ + drop_cnt < DEPTH)`. Both `occ` and `drop_cnt` are registered values.
- **Accept.** A request is accepted on `imem_req_valid & imem_req_ready`. Accepting it:
  - allocates the entry at `alloc_ptr`, with `filled`=0;
  - sets `slot1_ok = pc_valid_in[1] & ~pred_branch_in[0] & (pc_in[1] == pc_in[0]+4)`.
- **stall_out** = ~accept.
- **Response.**
  - If `drop_cnt`>0: `drop_cnt` decrements and the data is discarded.
  - Otherwise: data is written to the entry at `fill_ptr`, `filled` is set, and `fill_ptr` advances.
- **Decode outputs.** Taken from the head entry:
  - `dec_valid[0] = occ>0 & filled`;
  - `dec_valid[1] = dec_valid[0] & slot1_ok`.
- **Pop.** Occurs on `dec_valid[0] & dec_ready`; `head_ptr` advances.
- **Flush** (highest priority):
  - the queue empties: all pointers go to 0 and `occ` goes to 0;
  - `drop_cnt_next = drop_cnt + unfilled - imem_resp_valid`, where `unfilled` = allocated-but-unfilled entries;
  - no request is issued in the flush cycle;
  - a response in the flush cycle is dropped.
- **Invariant.** `drop_cnt + unfilled ≤ DEPTH`. Assert it.
- **Arithmetic.** Pointers wrap modulo `DEPTH`; the PC+4 compare is done at `ADDR_WIDTH`.

## Timing
- **Reset values.** All pointers, `occ`, `drop_cnt` and `filled` bits are 0. `dec_valid` is 0 and `imem_req_valid` is 0. `stall_out` is 1 while reset is asserted. Data fields are don't-care.
- **Combinational paths.** `imem_req_valid`, `imem_req_addr` and `stall_out` are combinational from `pc_*_in`, `ext_flush` and registered state. Decode outputs are registered state only.
- **Latency.** Request accepted in cycle N, response in N+k → `dec_valid` in N+k+1. Minimum is N+2.
- **Same-cycle accept/pop.** Accept and pop in the same cycle are allowed. A pop frees its credit only from the next cycle. Net `occ` change = accept − pop.
- **Same-cycle response/pop.** A response and a pop in the same cycle touch different entries, because a filled entry becomes visible a cycle later.
- **Full.** When `occ + drop_cnt == DEPTH`, `stall_out`=1 and the predictor holds its PCs.
- **Flush with accept.** `ext_flush` together with `pc_valid_in` gives no accept and `stall_out`=1. The predictor redirects in that same cycle.
- **Reset mid-operation.** Everything clears immediately, including `drop_cnt`; the memory is reset by the same signal.

## Structure
- Into `riscv_core.svh`:
  - `INSTR_WIDTH` constant;
  - `fetch_entry_t` packed struct: `pc[2]`, `slot1_ok`, `pred[2]`, `instr[2]`, `filled`.
- No sub-module. The queue is small; pointers and the entry array are inline.

## Test plan
- **Basic fetch.** Reset, then PCs 0/4 with 1-cycle memory, data 0x00000013/0x00100093 → request addr 0. Decode two cycles later shows PCs 0/4, both slots valid.
- **Back-pressure.** `dec_ready`=0, `DEPTH`=4, memory always ready → exactly 4 accepts, then `stall_out`=1. Raise `dec_ready` for one cycle → one pop, and a new accept the following cycle.
- **Slot-1 kill.** `pred_branch_in[0]`=1 → `dec_valid[1]`=0. Separately, `pc_in[1]` = `pc_in[0]`+8 → `dec_valid[1]`=0.
- **Flush with in-flight fetches.** 3 requests outstanding with 5-cycle latency, `ext_flush` asserted → `drop_cnt`=3. The 3 old responses are discarded, then the redirected PC 0x100 appears first at decode.
- **Flush during drop.** Second flush while `drop_cnt`=2 and 1 unfilled entry → `drop_cnt`=3. Only the post-flush data reaches decode.
- **Async reset mid-burst.** Assert `reset` between clock edges → outputs clear without waiting for an edge. Credits are back to `DEPTH` after release.
